// File: rtl/zxbus_pkg.sv
// zxbus_pkg: GS port addresses, op/control encodings and FSM state types for the ZX-side host.
package zxbus_pkg;
  localparam logic [7:0] GSDAT = 8'hB3;
  localparam logic [7:0] GSCOM = 8'hBB;
  localparam logic [7:0] GSCTR = 8'h33;
  localparam logic [2:0] RST = 3'b100;
  localparam logic [2:0] NMI = 3'b010;
  localparam logic [2:0] LED = 3'b001;
  typedef enum logic [2:0] {
    OP_WRDAT, OP_WRCMD, OP_RDDAT, OP_RDSTAT, OP_WRCTR, OP_CMDHS, OP_DATHS, OP_RSV
  } op_e;
  typedef enum logic [2:0] {TS_IDLE, TS_T1, TS_T2, TS_TW, TS_T3, TS_T4} tstate_e;
  typedef enum logic [1:0] {OC_IDLE, OC_CYC, OC_EVAL, OC_FIN} opc_e;
endpackage

// File: rtl/zxbus_host_cycle.sv
// zxbus_host_cycle: one Z80 I/O cycle (T1,T2,TW,T3,T4), TSTATE_DIV clocks per T-state.
// ZXBUS_HOST_WAIT_EN: /WAIT sampled on the last clock of TW stretches TW by whole T-states.
import zxbus_pkg::*;
module zxbus_host_cycle #(
  parameter int TSTATE_DIV = 4
) (
  input  logic       cpu_clock,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rd,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  input  logic [7:0] zxd_in,
  input  logic       zxblkiorq_n,
  input  logic       zxwait_n,
  output logic       cyc_done,
  output logic       noack_hit,
  output logic [7:0] rbyte,
  output logic [7:0] zxa,
  output logic [7:0] zxd_out,
  output logic       zxd_oe,
  output logic       zxiorq_n,
  output logic       zxrd_n,
  output logic       zxwr_n
);
  localparam int CW = $clog2(TSTATE_DIV);
  tstate_e st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rd_q, rd_d;
  logic [7:0] addr_q, addr_d, data_q, data_d, rbyte_q, rbyte_d;
  logic last, load, hold, strobe;
  assign last = cnt_q == CW'(TSTATE_DIV - 1);
`ifdef ZXBUS_HOST_WAIT_EN
  assign hold = !zxwait_n;
`else
  logic unused_wait;
  assign unused_wait = zxwait_n;
  assign hold = 1'b0;
`endif
  assign cyc_done = st_q == TS_T4 && last;
  // a start in the last clock of T4 chains straight into the next T1
  assign load = start && (st_q == TS_IDLE || cyc_done);
  always_comb begin
    st_d = st_q;
    case (st_q)
      TS_IDLE: st_d = start ? TS_T1 : TS_IDLE;
      TS_T1:   st_d = last ? TS_T2 : TS_T1;
      TS_T2:   st_d = last ? TS_TW : TS_T2;
      TS_TW:   st_d = (last && !hold) ? TS_T3 : TS_TW;
      TS_T3:   st_d = last ? TS_T4 : TS_T3;
      TS_T4:   st_d = last ? (start ? TS_T1 : TS_IDLE) : TS_T4;
      default: st_d = TS_IDLE;
    endcase
    cnt_d = (st_q == TS_IDLE || last) ? '0 : cnt_q + 1'b1;
    rd_d = load ? rd : rd_q;
    addr_d = load ? addr : addr_q;
    data_d = (load && !rd) ? data : data_q;
    rbyte_d = (st_q == TS_T3 && last && rd_q) ? zxd_in : rbyte_q;
  end
  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= TS_IDLE;
      cnt_q <= '0;
      rd_q <= 1'b0;
      addr_q <= 8'h00;
      data_q <= 8'h00;
      rbyte_q <= 8'h00;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      addr_q <= addr_d;
      data_q <= data_d;
      rbyte_q <= rbyte_d;
    end
  end
  assign strobe = st_q inside {TS_T2, TS_TW, TS_T3};
  assign zxiorq_n = !strobe;
  assign zxrd_n = !(strobe && rd_q);
  assign zxwr_n = !(strobe && !rd_q);
  assign zxd_oe = !rd_q && st_q != TS_IDLE;
  assign zxd_out = data_q;
  assign zxa = addr_q;
  assign rbyte = rbyte_q;
  assign noack_hit = st_q == TS_T2 && cnt_q == '0 && zxblkiorq_n;
endmodule

// File: rtl/zxbus_host.sv
// zxbus_host: GS port initiator; decodes ops and runs the command/data status-poll handshakes.
// Optional ZXBUS_HOST_WAIT_EN enables /WAIT stretching in the cycle sequencer.
import zxbus_pkg::*;
module zxbus_host #(
  parameter int          TSTATE_DIV = 4,
  parameter logic [15:0] POLL_MAX   = 16'd1000
) (
  input  logic       cpu_clock,
  input  logic       rst_n,
  input  logic       req,
  input  logic [2:0] op,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic       noack,
  output logic [7:0] zxa,
  output logic       zxa14,
  output logic       zxa15,
  output logic       zxiorq_n,
  output logic       zxrd_n,
  output logic       zxwr_n,
  output logic       zxmreq_n,
  output logic [7:0] zxd_out,
  output logic       zxd_oe,
  input  logic [7:0] zxd_in,
  input  logic       zxblkiorq_n,
  input  logic       zxwait_n
);
  opc_e st_q, st_d;
  op_e op_q, op_d, op_i;
  logic [15:0] cnt_q, cnt_d;
  logic to_q, to_d, na_q, na_d;
  logic start, rd, accept, met, cyc_done, noack_hit;
  logic [7:0] addr;
  zxbus_host_cycle #(.TSTATE_DIV(TSTATE_DIV)) u_cycle (
    .cpu_clock(cpu_clock), .rst_n(rst_n), .start(start), .rd(rd), .addr(addr), .data(wdata),
    .zxd_in(zxd_in), .zxblkiorq_n(zxblkiorq_n), .zxwait_n(zxwait_n), .cyc_done(cyc_done),
    .noack_hit(noack_hit), .rbyte(rdata), .zxa(zxa), .zxd_out(zxd_out), .zxd_oe(zxd_oe),
    .zxiorq_n(zxiorq_n), .zxrd_n(zxrd_n), .zxwr_n(zxwr_n)
  );
  assign op_i = op_e'(op);
  assign busy = st_q == OC_CYC || st_q == OC_EVAL;
  assign accept = req && !busy;
  assign met = op_q == OP_CMDHS ? !rdata[0] : rdata[7];
  // cnt_q counts status reads; zero in EVAL means the CMDHS command write just finished
  always_comb begin
    st_d = st_q;
    op_d = op_q;
    cnt_d = cnt_q;
    to_d = 1'b0;
    start = 1'b0;
    rd = 1'b1;
    addr = GSCOM;
    na_d = accept ? 1'b0 : na_q | noack_hit;
    case (st_q)
      OC_CYC: st_d = cyc_done ? OC_FIN : OC_CYC;
      OC_EVAL: begin
        if (cyc_done) begin
          if (cnt_q != '0 && met) begin
            start = op_q == OP_DATHS;
            addr = GSDAT;
            st_d = op_q == OP_DATHS ? OC_CYC : OC_FIN;
          end else if (cnt_q != '0 && cnt_q >= POLL_MAX) begin
            to_d = 1'b1;
            st_d = OC_FIN;
          end else begin
            start = 1'b1;
            cnt_d = cnt_q == 16'hFFFF ? cnt_q : cnt_q + 1'b1;
          end
        end
      end
      default: begin
        st_d = OC_IDLE;
        if (accept) begin
          op_d = op_i;
          cnt_d = op_i == OP_DATHS ? 16'd1 : 16'd0;
          start = op_i != OP_RSV;
          rd = op_i inside {OP_RDDAT, OP_RDSTAT, OP_DATHS};
          addr = op_i inside {OP_WRDAT, OP_RDDAT} ? GSDAT : op_i == OP_WRCTR ? GSCTR : GSCOM;
          st_d = op_i == OP_RSV ? OC_FIN : op_i inside {OP_CMDHS, OP_DATHS} ? OC_EVAL : OC_CYC;
        end
      end
    endcase
  end
  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= OC_IDLE;
      op_q <= OP_WRDAT;
      cnt_q <= 16'd0;
      to_q <= 1'b0;
      na_q <= 1'b0;
    end else begin
      st_q <= st_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
      na_q <= na_d;
    end
  end
  assign done = st_q == OC_FIN;
  assign timeout = to_q;
  assign noack = na_q;
  assign zxa14 = 1'b1;
  assign zxa15 = 1'b1;
  assign zxmreq_n = 1'b1;
endmodule

// File: tb/tb_zxbus_host.sv
// tb_zxbus_host: scoreboard bench for zxbus_host against a small GS card model.
import zxbus_pkg::*;
module tb_zxbus_host;
  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, blk = 1'b0, wait_n = 1'b1;
  logic [2:0] op = 3'd0;
  logic [7:0] wdata = 8'h00, zxd_in, rdata, zxa, zxd_out, status;
  logic busy, done, timeout, noack, zxa14, zxa15, zxiorq_n, zxrd_n, zxwr_n, zxmreq_n, zxd_oe;
  always #5 clk = ~clk;
  zxbus_host #(.TSTATE_DIV(4), .POLL_MAX(16'd5)) dut (
    .cpu_clock(clk), .rst_n(rst_n), .req(req), .op(op), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .timeout(timeout), .noack(noack), .zxa(zxa), .zxa14(zxa14),
    .zxa15(zxa15), .zxiorq_n(zxiorq_n), .zxrd_n(zxrd_n), .zxwr_n(zxwr_n), .zxmreq_n(zxmreq_n),
    .zxd_out(zxd_out), .zxd_oe(zxd_oe), .zxd_in(zxd_in), .zxblkiorq_n(blk), .zxwait_n(wait_n)
  );
`ifdef ZXBUS_HOST_WAIT_EN
  localparam int WSTR = 8;
`else
  localparam int WSTR = 0;
`endif
  // card model: status register behaviour selected by mode, data port always C3
  int mode = 0, bb_base = 0;
  int bb_rd = 0, b3_rd = 0, bb_wr = 0, b3_wr = 0, ctr_wr = 0, nmi_cnt = 0;
  logic [7:0] bb_wdat = 8'h00, ctr_wdat = 8'h00;
  always_comb status = mode == 0 ? ((bb_rd - bb_base >= 2) ? 8'h00 : 8'h01) :
                       mode == 1 ? 8'h7E : 8'h80;
  assign zxd_in = zxrd_n ? 8'hFF : zxa == GSCOM ? status : zxa == GSDAT ? 8'hC3 : 8'hFF;
  always @(posedge zxrd_n) begin
    if (zxa == GSCOM) bb_rd++;
    else if (zxa == GSDAT) b3_rd++;
  end
  always @(posedge zxwr_n) begin
    if (zxa == GSCOM) begin bb_wr++; bb_wdat = zxd_out; end
    else if (zxa == GSDAT) b3_wr++;
    else if (zxa == GSCTR) begin
      ctr_wr++;
      ctr_wdat = zxd_out;
      if (zxd_out[7:5] == NMI) nmi_cnt++;
    end
  end
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  typedef struct {logic [7:0] rd; logic to; logic na; int n;} exp_t;
  exp_t sb[$];
  int done_n, io_first, io_last, io_cnt, wr_cnt, rd_cnt;
  logic oe_seen, busy1;
  logic [7:0] zxa1, dout20;
  task automatic run_op(input logic [2:0] o, input logic [7:0] w, input logic [7:0] erd,
                        input logic eto, input logic ena, input int en);
    exp_t e, g;
    e.rd = erd; e.to = eto; e.na = ena; e.n = en;
    sb.push_back(e);
    done_n = 0; io_first = 0; io_last = 0; io_cnt = 0; wr_cnt = 0; rd_cnt = 0; oe_seen = 1'b0;
    @(negedge clk);
    op = o; wdata = w; req = 1'b1;
    for (int n = 1; n <= 400 && done_n == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin req = 1'b0; zxa1 = zxa; busy1 = busy; end
      if (n == 18) wait_n = 1'b1;
      if (!zxiorq_n) begin
        if (io_first == 0) io_first = n;
        io_last = n;
        io_cnt++;
      end
      wr_cnt += int'(!zxwr_n);
      rd_cnt += int'(!zxrd_n);
      oe_seen |= zxd_oe;
      if (n == 20) dout20 = zxd_out;
      if (done) begin done_n = n; g.rd = rdata; g.to = timeout; g.na = noack; end
    end
    e = sb.pop_front();
    if (done_n == 0) chk("done_seen", 0, 1);
    else begin
      chk("done_clk", done_n, e.n);
      chk("rdata", g.rd, e.rd);
      chk("timeout", g.to, e.to);
      chk("noack", g.na, e.na);
    end
  endtask
  int b0, b1, b2, d1, d2;
  logic saw_done;
  initial begin
    #1;
    chk("rst_iorq", zxiorq_n, 1); chk("rst_rd", zxrd_n, 1); chk("rst_wr", zxwr_n, 1);
    chk("rst_zxa", zxa, 0); chk("rst_oe", zxd_oe, 0); chk("rst_dout", zxd_out, 0);
    chk("rst_rdata", rdata, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_noack", noack, 0); chk("fixed_hi", {zxa14, zxa15, zxmreq_n}, 3'b111);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b0 = b3_wr;
    run_op(3'd0, 8'h5A, 8'h00, 1'b0, 1'b0, 21);
    chk("wr_zxa1", zxa1, GSDAT); chk("wr_busy1", busy1, 1);
    chk("wr_io_first", io_first, 5); chk("wr_io_last", io_last, 16);
    chk("wr_wr_cnt", wr_cnt, 12); chk("wr_dout20", dout20, 8'h5A);
    chk("wr_oe", oe_seen, 1); chk("wr_card", b3_wr - b0, 1);
    b0 = b3_rd;
    run_op(3'd2, 8'h00, 8'hC3, 1'b0, 1'b0, 21);
    chk("rd_rd_cnt", rd_cnt, 12); chk("rd_oe", oe_seen, 0); chk("rd_card", b3_rd - b0, 1);
    mode = 0; bb_base = bb_rd; b0 = bb_wr;
    run_op(3'd5, 8'h10, 8'h00, 1'b0, 1'b0, 81);
    chk("cmdhs_wr", bb_wr - b0, 1); chk("cmdhs_wdat", bb_wdat, 8'h10);
    chk("cmdhs_reads", bb_rd - bb_base, 3);
    mode = 1; b0 = bb_rd; b1 = b3_rd;
    run_op(3'd6, 8'h00, 8'h7E, 1'b1, 1'b0, 101);
    chk("daths_to_reads", bb_rd - b0, 5); chk("daths_to_b3", b3_rd - b1, 0);
    mode = 2; b0 = bb_rd; b1 = b3_rd;
    run_op(3'd6, 8'h00, 8'hC3, 1'b0, 1'b0, 41);
    chk("daths_reads", bb_rd - b0, 1); chk("daths_b3", b3_rd - b1, 1);
    blk = 1'b1; b0 = ctr_wr; b1 = nmi_cnt;
    run_op(3'd4, {NMI, 5'b0}, 8'hC3, 1'b0, 1'b1, 21);
    chk("ctr_wr", ctr_wr - b0, 1); chk("ctr_wdat", ctr_wdat, 8'h40); chk("ctr_nmi", nmi_cnt - b1, 1);
    blk = 1'b0;
    run_op(3'd7, 8'h00, 8'hC3, 1'b0, 1'b0, 1);
    chk("rsv_io", io_cnt, 0);
    wait_n = 1'b0;
    run_op(3'd0, 8'h22, 8'hC3, 1'b0, 1'b0, 21 + WSTR);
    chk("wait_io", io_cnt, 12 + WSTR);
    d1 = 0; d2 = 0; b0 = b3_wr;
    @(negedge clk);
    op = 3'd0; wdata = 8'h11; req = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (n == 22) req = 1'b0;
      if (done && d1 == 0) d1 = n;
      else if (done && d2 == 0) d2 = n;
    end
    chk("b2b_d1", d1, 21); chk("b2b_d2", d2, 42); chk("b2b_wr", b3_wr - b0, 2);
    @(negedge clk);
    op = 3'd0; wdata = 8'h77; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_iorq", zxiorq_n, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_iorq", zxiorq_n, 1); chk("arst_wr", zxwr_n, 1);
    chk("arst_busy", busy, 0); chk("arst_oe", zxd_oe, 0);
    saw_done = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 3) rst_n = 1'b1;
      saw_done |= done;
    end
    chk("arst_no_done", saw_done, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
